// File: rtl/quadrature_generator_pkg.sv
// Shared types and edge tables for the quadrature (A/B) step generator.
package quadrature_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

    localparam logic       DIR_UP   = 1'b1;
    localparam logic       DIR_DOWN = 1'b0;
    localparam logic [1:0] IDLE_AB  = 2'b11;
    localparam int         STEPS_W  = 8;
    localparam int         POS_W    = 16;

    // Bit i set: phase i toggles A; clear: phase i toggles B.
    localparam logic [3:0] UP_EDGE_A   = 4'b1010;
    localparam logic [3:0] DOWN_EDGE_A = 4'b0101;

    // XOR mask applied to {a,b} for the edge at a given phase index.
    function automatic logic [1:0] edge_mask(input logic dir, input logic [1:0] phase);
        logic sel_a;
        sel_a = (dir == DIR_UP) ? UP_EDGE_A[phase] : DOWN_EDGE_A[phase];
        return sel_a ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/quadrature_generator_if.sv
// Step-command handshake between a command source and the quadrature generator.
interface quadrature_generator_if;
    import quadrature_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dir;
    logic [STEPS_W-1:0] cmd_steps;

    modport master (output cmd_valid, output cmd_dir, output cmd_steps, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_dir, input cmd_steps, output cmd_ready);

endinterface

// File: rtl/quadrature_generator_phase_timer.sv
// Down-counter that ticks once every PHASE_CYCLES enabled clocks; load restarts the interval.
module phase_timer #(
    parameter int PHASE_CYCLES = 1000,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PHASE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/quadrature_generator.sv
// Transmit side of a rotary-encoder interface: turns step commands into Gray-coded A/B edges.
module quadrature_generator
    import quadrature_pkg::*;
#(
    parameter int PHASE_CYCLES = 1000,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    quadrature_generator_if.slave  cmd,
    output logic                   a,
    output logic                   b,
    output logic                   busy,
    output logic                   done,
    output logic [POS_W-1:0]       position
);

    state_e             state_q, state_d;
    logic               dir_q, dir_d;
    logic [STEPS_W-1:0] steps_q, steps_d;
    logic [1:0]         phase_q, phase_d;
    logic [1:0]         ab_q, ab_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               accept;
    logic               tick;

    assign accept = cmd.cmd_valid && (state_q == IDLE);

    phase_timer #(
        .PHASE_CYCLES (PHASE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (accept),
        .en_i   (state_q == RUN),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        steps_d = steps_q;
        phase_d = phase_q;
        ab_d    = ab_q;
        pos_d   = pos_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dir_d   = cmd.cmd_dir;
                    steps_d = cmd.cmd_steps;
                    phase_d = 2'd0;
                    state_d = (cmd.cmd_steps != '0) ? RUN : FINISH;
                end
            end
            RUN: begin
                if (tick) begin
                    ab_d    = ab_q ^ edge_mask(dir_q, phase_q);
                    phase_d = phase_q + 2'd1;
                    // Phase 3 closes the detent back at 11.
                    if (phase_q == 2'd3) begin
                        pos_d   = (dir_q == DIR_UP) ? pos_q + 1'b1 : pos_q - 1'b1;
                        steps_d = steps_q - 1'b1;
                        if (steps_q == STEPS_W'(1)) state_d = FINISH;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= DIR_DOWN;
            steps_q <= '0;
            phase_q <= 2'd0;
            ab_q    <= IDLE_AB;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            steps_q <= steps_d;
            phase_q <= phase_d;
            ab_q    <= ab_d;
            pos_q   <= pos_d;
        end
    end

    assign cmd.cmd_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == FINISH);
    assign a             = ab_q[1];
    assign b             = ab_q[0];
    assign position      = pos_q;

endmodule

// File: tb/tb_quadrature_generator.sv
// Scoreboard bench: commands push expected edges/done records; a negedge monitor pops and checks.
module tb_quadrature_generator;

    localparam int P = 4;

    typedef struct { logic [1:0] ab; int cyc; } edge_t;
    typedef struct { int cyc; logic [15:0] pos; } done_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a, b, busy, done;
    logic [15:0] position;

    quadrature_generator_if qif();

    quadrature_generator #(.PHASE_CYCLES(P), .CNT_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd      (qif.slave),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .position (position)
    );

    always #5 clk = ~clk;

    edge_t      eq[$];
    done_t      dq[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         last_done_cyc = -1;
    int         dec = 0;
    logic [1:0] prev_ab = 2'b11;
    logic [1:0] up_seq[4]   = '{2'b10, 2'b00, 2'b01, 2'b11};
    logic [1:0] down_seq[4] = '{2'b01, 2'b00, 2'b10, 2'b11};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int gidx(input logic [1:0] ab);
        case (ab)
            2'b11:   return 0;
            2'b10:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    // Monitor plus a small quadrature decoder counting quarter-steps.
    always @(negedge clk) begin : monitor
        edge_t e;
        done_t d;
        int    dl;
        if (reset) begin
            prev_ab = 2'b11;
        end else begin
            if ({a, b} != prev_ab) begin
                chk($countones({a, b} ^ prev_ab) == 1, "single_toggle", int'({a, b}), int'(prev_ab));
                dl = (gidx({a, b}) - gidx(prev_ab)) & 3;
                if (dl == 1) dec++;
                else if (dl == 3) dec--;
                if (eq.size() == 0) begin
                    chk(1'b0, "unexpected_edge", int'({a, b}), int'(prev_ab));
                end else begin
                    e = eq.pop_front();
                    chk({a, b} == e.ab, "edge_ab", int'({a, b}), int'(e.ab));
                    chk(cyc == e.cyc, "edge_cycle", cyc, e.cyc);
                end
                prev_ab = {a, b};
            end
            if (done) begin
                last_done_cyc = cyc;
                if (dq.size() == 0) begin
                    chk(1'b0, "unexpected_done", cyc, -1);
                end else begin
                    d = dq.pop_front();
                    chk(cyc == d.cyc, "done_cycle", cyc, d.cyc);
                    chk(position == d.pos, "done_position", int'(position), int'(d.pos));
                    chk({a, b} == 2'b11, "done_ab_idle", int'({a, b}), 3);
                end
            end
            chk(qif.cmd_ready == !busy, "ready_vs_busy", int'(qif.cmd_ready), int'(!busy));
        end
    end

    task automatic issue(input logic dir, input logic [7:0] steps, input logic [15:0] exp_pos,
                         output int acc);
        int n;
        acc = -1;
        @(negedge clk);
        qif.cmd_valid = 1'b1;
        qif.cmd_dir   = dir;
        qif.cmd_steps = steps;
        n = 0;
        while (!qif.cmd_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!qif.cmd_ready) begin
            chk(1'b0, "accept_timeout", n, 4000);
            qif.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        qif.cmd_valid = 1'b0;
        // Scramble the command fields; the block must have latched them already.
        qif.cmd_dir   = ~dir;
        qif.cmd_steps = 8'hA5;
        for (int s = 0; s < int'(steps); s++)
            for (int p = 0; p < 4; p++)
                eq.push_back('{dir ? up_seq[p] : down_seq[p], acc + (4 * s + p + 1) * P});
        dq.push_back('{acc + 4 * int'(steps) * P, exp_pos});
    endtask

    task automatic drain();
        int n = 0;
        while ((eq.size() != 0 || dq.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(eq.size() == 0 && dq.size() == 0, "drain", eq.size() + dq.size(), 0);
        @(negedge clk);
    endtask

    initial begin : main
        int          acc, acc2, d0, n;
        logic [15:0] p0, diff;
        qif.cmd_valid = 1'b0;
        qif.cmd_dir   = 1'b0;
        qif.cmd_steps = 8'd0;
        repeat (3) @(negedge clk);
        chk(a == 1'b1, "reset_a", int'(a), 1);
        chk(b == 1'b1, "reset_b", int'(b), 1);
        chk(position == 16'h0000, "reset_position", int'(position), 0);
        chk(busy == 1'b0, "reset_busy", int'(busy), 0);
        chk(done == 1'b0, "reset_done", int'(done), 0);
        chk(qif.cmd_ready == 1'b1, "reset_ready", int'(qif.cmd_ready), 1);
        reset = 1'b0;

        // Wrap below zero and back, then single up and a 3-step down.
        issue(1'b0, 8'd1, 16'hFFFF, acc); drain();
        issue(1'b1, 8'd1, 16'h0000, acc); drain();
        issue(1'b1, 8'd1, 16'h0001, acc); drain();
        issue(1'b0, 8'd3, 16'hFFFE, acc); drain();

        // Zero steps: done right after acceptance, no edges expected.
        issue(1'b1, 8'd0, 16'hFFFE, acc); drain();

        // Second command held during busy is accepted two cycles after the first done.
        issue(1'b1, 8'd2, 16'h0000, acc);
        issue(1'b0, 8'd1, 16'hFFFF, acc2);
        chk(acc2 == last_done_cyc + 2, "held_accept_cycle", acc2, last_done_cyc + 2);
        drain();

        // Loopback: decoder delta must match the position change.
        d0 = dec;
        p0 = position;
        issue(1'b1, 8'd10, 16'h0009, acc);
        issue(1'b0, 8'd4, 16'h0005, acc);
        drain();
        diff = position - p0;
        chk(dec - d0 == 24, "decoder_quarters", dec - d0, 24);
        chk(diff == 16'd6, "position_delta", int'(diff), 6);
        chk((dec - d0) / 4 == int'($signed(diff)), "decoder_vs_position", (dec - d0) / 4, int'($signed(diff)));

        // Reset between phase 1 and phase 2 of an up step.
        issue(1'b1, 8'd1, 16'h0006, acc);
        n = 0;
        while ({a, b} != 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({a, b} == 2'b00, "midstep_reached", int'({a, b}), 0);
        #2 reset = 1'b1;
        #1;
        chk(a == 1'b1 && b == 1'b1, "async_reset_ab", int'({a, b}), 3);
        chk(position == 16'h0000, "async_reset_position", int'(position), 0);
        eq.delete();
        dq.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk(qif.cmd_ready == 1'b1, "ready_after_reset", int'(qif.cmd_ready), 1);
        chk(busy == 1'b0, "busy_after_reset", int'(busy), 0);
        repeat (20) @(negedge clk);
        chk({a, b} == 2'b11, "idle_after_reset", int'({a, b}), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quadrature_generator.md
# quadrature_generator

Quadrature-signal generator: it is the transmit side of a two-phase (A/B) rotary encoder interface. It accepts step commands (direction plus count) over a valid/ready handshake and drives Gray-coded A/B outputs, one full four-edge cycle per detent. The outputs can drive a quadrature decoder in loopback, stand in for a Pmod ENC in simulation and board bring-up, or emulate an encoder towards external equipment.

## Interface

Parameters:
- PHASE_CYCLES, default 1000: clk cycles between consecutive A/B edges. Legal range is ≥ 1.
- CNT_W, default 16: width of the phase timer. Must satisfy PHASE_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  a step command is presented.
- cmd_ready  out  1  the block can accept a command. High only in IDLE.
- cmd_dir  in  1  1 = up (decoder counts +1 per step), 0 = down.
- cmd_steps  in  8  number of detents to emit; 0 is legal.
- a  out  1  quadrature phase A, registered.
- b  out  1  quadrature phase B, registered.
- busy  out  1  a command is executing.
- done  out  1  one-cycle pulse when a command completes.
- position  out  16  signed count of emitted detents, wraps modulo 2^16.

## Operation

- Idle (detent) level is a=1, b=1.
- Up step sequence, as (a,b): 11→10→00→01→11. B falls, then A falls, then B rises, then A rises while b=1.
- Down step sequence, as (a,b): 11→01→00→10→11. A falls, then B falls, then A rises while b=0, then B rises.
- Exactly one of a/b changes per edge. A and B never toggle on the same cycle.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch dir and steps into internal registers. Go to RUN if steps≠0, else to FINISH.
  - RUN: a 2-bit phase index 0..3 selects which output toggles next. The phase timer ticks every PHASE_CYCLES clocks, and each tick applies one edge.
    - After the phase-3 edge: position ±1, remaining steps −1.
    - If remaining steps reach 0, go to FINISH. Otherwise stay in RUN with phase 0.
  - FINISH: done=1 for this single cycle, then go to IDLE.
- busy=1 in RUN and FINISH.
- cmd_dir and cmd_steps are sampled only at acceptance. Changes while busy have no effect.
- cmd_valid while busy is ignored and not queued. The command is held by the source until accepted.
- position arithmetic is 16-bit two's complement: 16'hFFFF + 1 = 16'h0000 and 16'h0000 − 1 = 16'hFFFF. No saturation.
- Reset values: a=1, b=1, position=0, busy=0, done=0, cmd_ready=1, state IDLE, phase=0, timer=0.
- Reset mid-step forces a and b to 1 immediately (asynchronously). Any partial detent is abandoned and position is not adjusted for it.

## Timing

- Acceptance happens at clock edge N (cmd_valid&&cmd_ready sampled high).
- The first A/B edge occurs at edge N+PHASE_CYCLES. Subsequent edges occur every PHASE_CYCLES cycles after that.
- A command of S steps places its last A/B edge at N+4·S·PHASE_CYCLES. position updates on that same edge.
- done is high during the cycle following that edge. cmd_ready is high one cycle after done.
- Zero-step command: accepted at N, done high in cycle N+1, cmd_ready high again in cycle N+2. a and b do not toggle.
- Per-step position update: within one multi-step command, position changes on each phase-3 edge.
- With PHASE_CYCLES=1, an edge occurs every cycle. The timer resets to 0 at acceptance, so no extra cycle is lost.

## Structure

- Shared package `quadrature_pkg`:
  - state enum {IDLE, RUN, FINISH};
  - DIR_UP=1, DIR_DOWN=0;
  - IDLE_AB=2'b11;
  - per-direction 4-entry edge tables giving which signal toggles at each phase index.
- One sub-module, `phase_timer`: a CNT_W-bit down-counter with load/enable that emits a one-cycle tick every PHASE_CYCLES clocks. It is reloaded at acceptance.

## Test plan

- PHASE_CYCLES=4, up, steps=1: a/b trace 11,10,00,01,11 with edges 4 cycles apart; position=1; one done pulse 16 cycles after acceptance.
- Down, steps=3: three full 11→01→00→10→11 cycles; position=16'hFFFD; cmd_ready low for the whole command.
- Wrap: from reset, down 1 then up 1. position goes 16'hFFFF, then 16'h0000.
- steps=0, and also cmd_valid with changed dir/steps held during busy. Required results:
  - steps=0 produces done on the next cycle with no a/b toggle;
  - the held command executes only after cmd_ready returns, using the values sampled at that acceptance.
- Reset asserted between phase 1 and phase 2 of an up step: a=b=1 immediately; position=0; cmd_ready=1 after release.
- Loopback with the team's quadrature decoder, PHASE_CYCLES=2:
  - up 10, down 4;
  - the decoder's count delta is +6 and equals the change in position;
  - the checker flags any cycle with simultaneous a/b toggles.
